// File: rtl/ntt_pkg.sv
// Shared constants for the Q = 65537 NTT core and the sequencer state encoding.
package ntt_pkg;

  localparam int unsigned LOGQ   = 17;
  localparam int unsigned Q      = 65537;
  localparam int unsigned TWOINV = 32769;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_state_e;

endpackage

// File: rtl/ntt_addr_delay.sv
// Fixed-depth shift register carrying {en, addr3..addr0} from the read side
// to the write-back side. Async clear empties the line so no stale write escapes.
// Ports: clk, rst (async, active-high), d (payload in), q (payload DEPTH cycles later).
module ntt_addr_delay #(
  parameter int unsigned W     = 17,
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < int'(DEPTH); i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/radix4_ntt_ctrl.sv
// Stage/butterfly sequencer for the in-place radix-4 DIF NTT.
// Ports: clk, rst (async, active-high), start; busy, done, stage;
// rd_en, rd_addr0..3, tf_exp0..3 (operand read + twiddle exponents);
// wr_en, wr_addr0..3 (same addresses PIPE_LAT cycles later).
module radix4_ntt_ctrl
  import ntt_pkg::*;
#(
  parameter int unsigned LOGN   = 4,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BF_LAT = 1,
  localparam int unsigned NS    = LOGN / 2,
  localparam int unsigned SW    = (NS > 1) ? $clog2(NS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr0,
  output logic [LOGN-1:0] rd_addr1,
  output logic [LOGN-1:0] rd_addr2,
  output logic [LOGN-1:0] rd_addr3,
  output logic [LOGN-1:0] tf_exp0,
  output logic [LOGN-1:0] tf_exp1,
  output logic [LOGN-1:0] tf_exp2,
  output logic [LOGN-1:0] tf_exp3,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr0,
  output logic [LOGN-1:0] wr_addr1,
  output logic [LOGN-1:0] wr_addr2,
  output logic [LOGN-1:0] wr_addr3,
  output logic [SW-1:0]   stage
);

  localparam int unsigned PIPE_LAT = RD_LAT + BF_LAT;
  localparam int unsigned BW       = (LOGN > 2) ? LOGN - 2 : 1;
  localparam int unsigned DW       = $clog2(PIPE_LAT + 1);
  localparam int unsigned DLY_W    = 1 + 4 * LOGN;

  localparam logic [BW-1:0] B_LAST     = BW'((1 << (LOGN - 2)) - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(NS - 1);

  ctrl_state_e   state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [BW-1:0] b_q, b_d;
  logic [DW-1:0] dcnt_q, dcnt_d;

  logic            issue_c;
  logic [7:0]      span_sh_c, tw_sh_c;
  logic [LOGN-1:0] b_ext_c, span_c, j_c, base_c, t_c;
  logic [DLY_W-1:0] dly_q;

  // State and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      b_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      b_q     <= b_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    b_d     = b_q;
    dcnt_d  = dcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          stage_d = '0;
          b_d     = '0;
        end
      end
      ST_ISSUE: begin
        if (b_q == B_LAST) begin
          state_d = ST_DRAIN;
          dcnt_d  = '0;
        end else begin
          b_d = b_q + BW'(1);
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == DRAIN_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ISSUE;
            stage_d = stage_q + SW'(1);
            b_d     = '0;
          end
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        stage_d = '0;
        b_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Butterfly geometry: span is a power of two, so g/j split is a mask and
  // base = 4*(b - j) + j; twiddle step t = j * 4^stage.
  always_comb begin
    issue_c   = (state_q == ST_ISSUE);
    span_sh_c = 8'(LOGN - 2 - 2 * 32'(stage_q));
    tw_sh_c   = 8'(2 * 32'(stage_q));
    b_ext_c   = LOGN'(b_q);
    span_c    = LOGN'(1) << span_sh_c;
    j_c       = b_ext_c & (span_c - LOGN'(1));
    base_c    = ((b_ext_c - j_c) << 2) | j_c;
    t_c       = j_c << tw_sh_c;
  end

  // Registered read-side and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr0 <= '0;
      rd_addr1 <= '0;
      rd_addr2 <= '0;
      rd_addr3 <= '0;
      tf_exp0  <= '0;
      tf_exp1  <= '0;
      tf_exp2  <= '0;
      tf_exp3  <= '0;
      stage    <= '0;
    end else begin
      busy     <= (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
      done     <= (state_q == ST_DONE);
      rd_en    <= issue_c;
      rd_addr0 <= issue_c ? base_c : '0;
      rd_addr1 <= issue_c ? base_c + span_c : '0;
      rd_addr2 <= issue_c ? base_c + (span_c << 1) : '0;
      rd_addr3 <= issue_c ? base_c + (span_c << 1) + span_c : '0;
      // Output A1 carries frequency index 2, A2 index 1.
      tf_exp0  <= '0;
      tf_exp1  <= issue_c ? (t_c << 1) : '0;
      tf_exp2  <= issue_c ? t_c : '0;
      tf_exp3  <= issue_c ? (t_c << 1) + t_c : '0;
      stage    <= stage_q;
    end
  end

  // Write-back is the read request replayed after the memory+butterfly latency.
  ntt_addr_delay #(
    .W    (DLY_W),
    .DEPTH(PIPE_LAT)
  ) u_wr_delay (
    .clk(clk),
    .rst(rst),
    .d  ({rd_en, rd_addr3, rd_addr2, rd_addr1, rd_addr0}),
    .q  (dly_q)
  );

  assign {wr_en, wr_addr3, wr_addr2, wr_addr1, wr_addr0} = dly_q;

endmodule

// File: tb/tb_radix4_ntt_ctrl.sv
// Bench for radix4_ntt_ctrl: a small (LOGN=4, 1+1) and a large (LOGN=6, 2+0)
// instance, compared cycle by cycle with an arithmetic reference model.
module tb_radix4_ntt_ctrl;

  typedef logic [3:0][7:0] quad_t;

  typedef struct {
    int    sel;
    int    cyc;
    quad_t ra;
    quad_t te;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       s_start, s_busy, s_done, s_rd_en, s_wr_en;
  logic [3:0] s_ra0, s_ra1, s_ra2, s_ra3, s_te0, s_te1, s_te2, s_te3;
  logic [3:0] s_wa0, s_wa1, s_wa2, s_wa3;
  logic [0:0] s_stage;

  logic       l_start, l_busy, l_done, l_rd_en, l_wr_en;
  logic [5:0] l_ra0, l_ra1, l_ra2, l_ra3, l_te0, l_te1, l_te2, l_te3;
  logic [5:0] l_wa0, l_wa1, l_wa2, l_wa3;
  logic [1:0] l_stage;

  radix4_ntt_ctrl #(.LOGN(4), .RD_LAT(1), .BF_LAT(1)) u_small (
    .clk(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .rd_en(s_rd_en), .rd_addr0(s_ra0), .rd_addr1(s_ra1), .rd_addr2(s_ra2), .rd_addr3(s_ra3),
    .tf_exp0(s_te0), .tf_exp1(s_te1), .tf_exp2(s_te2), .tf_exp3(s_te3),
    .wr_en(s_wr_en), .wr_addr0(s_wa0), .wr_addr1(s_wa1), .wr_addr2(s_wa2), .wr_addr3(s_wa3),
    .stage(s_stage)
  );

  radix4_ntt_ctrl #(.LOGN(6), .RD_LAT(2), .BF_LAT(0)) u_large (
    .clk(clk), .rst(rst), .start(l_start), .busy(l_busy), .done(l_done),
    .rd_en(l_rd_en), .rd_addr0(l_ra0), .rd_addr1(l_ra1), .rd_addr2(l_ra2), .rd_addr3(l_ra3),
    .tf_exp0(l_te0), .tf_exp1(l_te1), .tf_exp2(l_te2), .tf_exp3(l_te3),
    .wr_en(l_wr_en), .wr_addr0(l_wa0), .wr_addr1(l_wa1), .wr_addr2(l_wa2), .wr_addr3(l_wa3),
    .stage(l_stage)
  );

  int checks = 0;
  int errors = 0;
  quad_t obs_ra [64];
  quad_t obs_te [64];
  quad_t obs_wa [64];
  vec_t  tbl [7];

  function automatic quad_t q4(input int a0, input int a1, input int a2, input int a3);
    return {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic int pow4(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 4;
    return r;
  endfunction

  // Reference: butterfly b of stage s, from the division/modulo definition.
  function automatic quad_t model_addr(input int logn, input int s, input int b);
    int n, span, g, j, base;
    n = 1 << logn; span = n / pow4(s + 1);
    g = b / span; j = b % span; base = 4 * g * span + j;
    return q4(base % n, (base + span) % n, (base + 2 * span) % n, (base + 3 * span) % n);
  endfunction

  function automatic quad_t model_exp(input int logn, input int s, input int b);
    int n, span, t;
    n = 1 << logn; span = n / pow4(s + 1);
    t = (b % span) * pow4(s);
    return q4(0, (2 * t) % n, t % n, (3 * t) % n);
  endfunction

  // Which butterfly (if any) is read in cycle c, counting from the start edge.
  function automatic bit issue_at(input int c, input int nb, input int per, input int ns,
                                  output int s, output int b);
    s = 0; b = 0;
    if (c < 1) return 1'b0;
    s = (c - 1) / per; b = (c - 1) % per;
    return (s < ns) && (b < nb);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chkq(input string name, input quad_t act, input quad_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_cycle(input string tag, input int logn, input int p, input int c,
                             input logic rd_en, input logic wr_en, input logic busy,
                             input logic done, input int stg,
                             input quad_t ra, input quad_t te, input quad_t wa);
    int nb, ns, per, s, b;
    bit e;
    nb = (1 << logn) / 4; ns = logn / 2; per = nb + p;
    e = issue_at(c, nb, per, ns, s, b);
    chk($sformatf("%s c%0d rd_en", tag, c), int'(rd_en), int'(e));
    if (e) begin
      chk($sformatf("%s c%0d stage", tag, c), stg, s);
      chkq($sformatf("%s c%0d rd_addr", tag, c), ra, model_addr(logn, s, b));
      chkq($sformatf("%s c%0d tf_exp", tag, c), te, model_exp(logn, s, b));
    end
    e = issue_at(c - p, nb, per, ns, s, b);
    chk($sformatf("%s c%0d wr_en", tag, c), int'(wr_en), int'(e));
    if (e) chkq($sformatf("%s c%0d wr_addr", tag, c), wa, model_addr(logn, s, b));
    chk($sformatf("%s c%0d busy", tag, c), int'(busy), int'(c >= 1 && c <= ns * per));
    chk($sformatf("%s c%0d done", tag, c), int'(done), int'(c == ns * per + 1));
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) s_start = v; else l_start = v;
  endtask

  // One transform; start is either held high or toggled randomly while busy.
  task automatic run_xfer(input int sel, input int held);
    int logn, p, last;
    quad_t ra, te, wa;
    logn = (sel == 0) ? 4 : 6;
    p    = 2;
    last = (logn / 2) * ((1 << logn) / 4 + p);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    #1;
    set_start(sel, held != 0 ? 1'b1 : 1'($urandom_range(0, 1)));
    for (int c = 1; c <= last + 3; c++) begin
      @(posedge clk);
      #1;
      if (sel == 0) begin
        ra = q4(s_ra0, s_ra1, s_ra2, s_ra3); te = q4(s_te0, s_te1, s_te2, s_te3);
        wa = q4(s_wa0, s_wa1, s_wa2, s_wa3);
        check_cycle("small", logn, p, c, s_rd_en, s_wr_en, s_busy, s_done, int'(s_stage), ra, te, wa);
      end else begin
        ra = q4(l_ra0, l_ra1, l_ra2, l_ra3); te = q4(l_te0, l_te1, l_te2, l_te3);
        wa = q4(l_wa0, l_wa1, l_wa2, l_wa3);
        check_cycle("large", logn, p, c, l_rd_en, l_wr_en, l_busy, l_done, int'(l_stage), ra, te, wa);
      end
      obs_ra[c] = ra; obs_te[c] = te; obs_wa[c] = wa;
      if (c < last) set_start(sel, held != 0 ? 1'b1 : 1'($urandom_range(0, 1)));
      else          set_start(sel, 1'b0);
    end
  endtask

  task automatic apply_table(input int sel);
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].sel == sel) begin
        chkq($sformatf("tbl%0d rd_addr", i), obs_ra[tbl[i].cyc], tbl[i].ra);
        chkq($sformatf("tbl%0d tf_exp", i), obs_te[tbl[i].cyc], tbl[i].te);
        chkq($sformatf("tbl%0d wr_addr", i), obs_wa[tbl[i].cyc + 2], tbl[i].ra);
      end
    end
  endtask

  task automatic check_small_zero(input string tag);
    chk({tag, " rd_en"}, int'(s_rd_en), 0);
    chk({tag, " wr_en"}, int'(s_wr_en), 0);
    chk({tag, " busy"}, int'(s_busy), 0);
    chk({tag, " done"}, int'(s_done), 0);
    chk({tag, " stage"}, int'(s_stage), 0);
    chkq({tag, " rd_addr"}, q4(s_ra0, s_ra1, s_ra2, s_ra3), q4(0, 0, 0, 0));
    chkq({tag, " tf_exp"}, q4(s_te0, s_te1, s_te2, s_te3), q4(0, 0, 0, 0));
    chkq({tag, " wr_addr"}, q4(s_wa0, s_wa1, s_wa2, s_wa3), q4(0, 0, 0, 0));
  endtask

  initial begin
    tbl[0] = '{0, 2,  q4(1, 5, 9, 13),   q4(0, 2, 1, 3)};
    tbl[1] = '{0, 4,  q4(3, 7, 11, 15),  q4(0, 6, 3, 9)};
    tbl[2] = '{0, 7,  q4(0, 1, 2, 3),    q4(0, 0, 0, 0)};
    tbl[3] = '{0, 8,  q4(4, 5, 6, 7),    q4(0, 0, 0, 0)};
    tbl[4] = '{1, 24, q4(17, 21, 25, 29), q4(0, 8, 4, 12)};
    tbl[5] = '{1, 42, q4(20, 21, 22, 23), q4(0, 0, 0, 0)};
    tbl[6] = '{1, 2,  q4(1, 17, 33, 49),  q4(0, 2, 1, 3)};

    rst = 1'b1; s_start = 1'b0; l_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_small_zero("reset");
    chk("reset large busy", int'(l_busy), 0);
    chk("reset large wr_en", int'(l_wr_en), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_xfer(0, 1);
    apply_table(0);
    for (int k = 0; k < 3; k++) run_xfer(0, 0);

    // Reset in the middle of stage-0 write-back.
    @(negedge clk);
    s_start = 1'b1;
    @(posedge clk);
    #1;
    s_start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_small_zero("midrst async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post-rst c%0d wr_en", c), int'(s_wr_en), 0);
      chk($sformatf("post-rst c%0d rd_en", c), int'(s_rd_en), 0);
    end
    run_xfer(0, 0);
    apply_table(0);

    run_xfer(1, 0);
    apply_table(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/radix4_ntt_ctrl.md
# radix4_ntt_ctrl

Sequencer for the combinational radix-4 DIF butterfly in the NTT core (17-bit, Q = 65537).
- Walks an in-place N-point transform stage by stage over a 4-read/4-write coefficient memory.
- Per butterfly it emits the four operand read addresses and the four twiddle exponents for the twiddle ROM.
- A fixed number of cycles later it emits the matching write-back addresses.
- Sits between the top-level start/done handshake and the memory, twiddle-ROM and butterfly datapath.

## Interface
Parameters:
- LOGN, 4, log2 of transform size; even, ≥ 2; S = LOGN/2 radix-4 stages.
- RD_LAT, 1, coefficient-memory read latency in cycles (≥ 1).
- BF_LAT, 1, register stages on the butterfly path (≥ 0).
- PIPE_LAT = RD_LAT + BF_LAT (derived, local).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  transform request; sampled only in IDLE.
- busy  out  1  high in ISSUE and DRAIN.
- done  out  1  one-cycle pulse when the final write has completed.
- rd_en  out  1  operand read strobe, one butterfly per cycle.
- rd_addr0..3  out  LOGN each  operand addresses.
- tf_exp0..3  out  LOGN each  twiddle exponents, mod N.
- wr_en  out  1  write-back strobe.
- wr_addr0..3  out  LOGN each  write addresses for butterfly outputs A0..A3.
- stage  out  max(1,clog2(S))  current stage index.

## Operation
- FSM states: IDLE → ISSUE → DRAIN → (ISSUE of the next stage, or DONE) → IDLE.
- IDLE:
  - start=1 moves to ISSUE with stage=0 and butterfly counter b=0.
  - Asserting start in any other state has no effect.
- ISSUE: one butterfly per cycle, b = 0 .. N/4−1. For stage s:
  - span = N/4^(s+1); g = b / span; j = b mod span.
  - base = 4·g·span + j.
  - rd_addr0..3 = base, base+span, base+2·span, base+3·span.
  - t = j·4^s; tf_exp0..3 = 0, 2t, t, 3t, each mod N. This matches butterfly output order: A1 carries frequency index 2, A2 carries index 1.
  - After b = N/4−1, go to DRAIN.
- DRAIN: PIPE_LAT cycles. Exit to ISSUE with stage+1 and b=0, or to DONE after stage S−1.
- DONE: done=1 for one cycle, then IDLE.
- Write-back:
  - wr_en and wr_addr0..3 are rd_en and rd_addr0..3 delayed by exactly PIPE_LAT cycles.
  - Write is in place: Ak goes to rd_addrk.
- Ordering: final memory contents are in digit-reversed order; reordering is the consumer's job.
- Arithmetic: all address and exponent math is unsigned, modulo 2^LOGN. Products are reduced mod N by truncation to LOGN bits.
- Reset, including mid-transform:
  - State → IDLE; stage, b, busy, done, rd_en and wr_en → 0.
  - All address and exponent outputs → 0.
  - The delay line is flushed, so in-flight writes are discarded and never issued.

## Timing
- All outputs are registered.
- start sampled high at edge 0 → first rd_en in cycle 1.
- Per stage: N/4 issue cycles plus PIPE_LAT drain cycles. The next stage's first read comes one cycle after the previous stage's last write, so no read-after-write hazard exists and the memory needs no bypass.
- done is asserted in cycle S·(N/4 + PIPE_LAT) + 1. busy is low in that cycle.
- start can be accepted again in the cycle after done.

## Structure
- Shared package ntt_pkg holds:
  - LOGQ=17, Q=65537, TWOINV=32769.
  - The controller state enum.
- Sub-module ntt_addr_delay: PIPE_LAT-deep shift register carrying {en, addr0..3}, with async clear on rst. Instantiated once for the write-back path.
- The remainder is the FSM and the stage/butterfly counters.

## Test plan
All scenarios use LOGN=4, RD_LAT=1, BF_LAT=1 unless stated.
- Start pulse → rd_en high cycles 1–4 and 7–10; wr_en high cycles 3–6 and 9–12; done in cycle 13 only; busy high cycles 1–12.
- Stage 0 sequence:
  - b=1 → rd_addr = 1,5,9,13 with tf_exp = 0,2,1,3.
  - b=3 → rd_addr = 3,7,11,15 with tf_exp = 0,6,3,9.
  - wr_addr repeats each rd_addr set 2 cycles later.
- Stage 1 sequence: b=1 → rd_addr = 4,5,6,7; all tf_exp = 0 for every stage-1 butterfly.
- start held high through an entire run → exactly one transform is performed; a second transform begins only after done, in IDLE.
- rst asserted in cycle 5 (mid-write):
  - All outputs are 0 asynchronously.
  - No wr_en pulse occurs after rst deasserts.
  - A new start reproduces the full first scenario.
- LOGN=6, RD_LAT=2, BF_LAT=0 → 3 stages of 16 issues each; done in cycle 55; stage 2, b=5 gives rd_addr 20–23.
